// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared ALU.
// One operation is in flight at a time: IDLE (grant/accept) -> EXEC (capture
// ALU outputs) -> RESP (hold result until the owner consumes it).
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   reqN_valid/ready/a/b/f      operation request from requester N
//   rspN_valid/ready/result/flags  response to requester N ({ov, c, n, z})
//   alu_a/alu_b/alu_f           operands to the shared ALU (registered)
//   alu_result, alu_*           combinational ALU outputs
//   busy                        high whenever not IDLE
module alu_arbiter #(
  parameter bit RR_EN = 1'b1   // 1: round-robin on ties, 0: requester 0 always wins
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_f,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_f,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_negative,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [31:0] op_a, op_b, res;
  logic [2:0]  op_f;
  logic [3:0]  flg;
  logic        owner;       // requester whose op is in flight
  logic        last_grant;  // requester most recently accepted
  logic        grant0, grant1;

  // Tie goes to requester 0 when fixed priority, or when requester 1 had the
  // last grant under round-robin. Reset value of last_grant=1 makes the first
  // tie go to requester 0.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !RR_EN || last_grant);
    grant1 = req1_valid && !grant0;
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_f       <= '0;
      res        <= '0;
      flg        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_a       <= req0_a;
            op_b       <= req0_b;
            op_f       <= req0_f;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_ready) begin
            op_a       <= req1_a;
            op_b       <= req1_b;
            op_f       <= req1_f;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res   <= alu_result;
          flg   <= {alu_overflow, alu_carry, alu_negative, alu_zero};
          state <= RESP;
        end
        RESP: begin
          // only the owner's ready completes the handshake
          if (owner ? rsp1_ready : rsp0_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_f       = op_f;
  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign rsp0_result = res;
  assign rsp1_result = res;
  assign rsp0_flags  = flg;
  assign rsp1_flags  = flg;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share stimulus; each gets its own
// behavioral ALU (add/sub/and/or/xor).
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_f, req1_f;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [2:0]  alu_f;
  logic        alu_zero, alu_overflow, alu_carry, alu_negative;

  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy;
  logic [31:0] f_rsp0_result, f_rsp1_result, f_alu_a, f_alu_b, f_alu_result;
  logic [3:0]  f_rsp0_flags, f_rsp1_flags;
  logic [2:0]  f_alu_f;
  logic        f_alu_zero, f_alu_overflow, f_alu_carry, f_alu_negative;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  // returns {overflow, carry, negative, zero, result}
  function automatic logic [35:0] alu_fn(input logic [31:0] a, b, input logic [2:0] f);
    logic [32:0] w;
    logic        ov, c;
    w = '0; ov = 1'b0; c = 1'b0;
    case (f)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; c = w[32]; ov = (a[31] == b[31]) && (w[31] != a[31]); end
      3'b001: begin w = {1'b0, a} - {1'b0, b}; c = ~w[32]; ov = (a[31] != b[31]) && (w[31] != a[31]); end
      3'b010: w = {1'b0, a & b};
      3'b011: w = {1'b0, a | b};
      3'b100: w = {1'b0, a ^ b};
      default: w = '0;
    endcase
    return {ov, c, w[31], (w[31:0] == 32'd0), w[31:0]};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_negative, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_f);
  always_comb {f_alu_overflow, f_alu_carry, f_alu_negative, f_alu_zero, f_alu_result} = alu_fn(f_alu_a, f_alu_b, f_alu_f);

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry), .alu_negative(alu_negative),
    .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(f_rsp0_result), .rsp0_flags(f_rsp0_flags),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(f_rsp1_result), .rsp1_flags(f_rsp1_flags),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_f(f_alu_f), .alu_result(f_alu_result),
    .alu_zero(f_alu_zero), .alu_overflow(f_alu_overflow), .alu_carry(f_alu_carry), .alu_negative(f_alu_negative),
    .busy(f_busy)
  );

  typedef struct {
    bit          r;
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [31:0] er;
    logic [3:0]  ef;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic run_op(input bit r, input logic [31:0] a, b, input logic [2:0] f,
                        input logic [31:0] er, input logic [3:0] ef);
    int n = 0;
    if (!r) begin req0_valid = 1; req0_a = a; req0_b = b; req0_f = f; end
    else    begin req1_valid = 1; req1_a = a; req1_b = b; req1_f = f; end
    #1;
    while (!(r ? req1_ready : req0_ready) && n < 8) begin step(); n++; end
    chk("accept_ready", 32'(r ? req1_ready : req0_ready), 32'd1);
    chk("other_ready_low", 32'(r ? req0_ready : req1_ready), 32'd0);
    step();
    // scramble inputs after accept: operand registers must hold the captured op
    req0_valid = 0; req1_valid = 0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b; req0_f = ~f; req1_f = ~f;
    #1;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    chk("alu_a_reg", alu_a, a);
    chk("alu_f_reg", 32'(alu_f), 32'(f));
    step();
    chk("rsp_valid", 32'(r ? rsp1_valid : rsp0_valid), 32'd1);
    chk("rsp_other_low", 32'(r ? rsp0_valid : rsp1_valid), 32'd0);
    chk("rsp_result", r ? rsp1_result : rsp0_result, er);
    chk("rsp_flags", 32'(r ? rsp1_flags : rsp0_flags), 32'(ef));
    if (r) rsp1_ready = 1; else rsp0_ready = 1;
    step();
    rsp0_ready = 0; rsp1_ready = 0;
    chk("idle_after_rsp", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vt[0] = '{1'b0, 32'd5,        32'd7,        3'b000, 32'd12,       4'b0000};
    vt[1] = '{1'b0, 32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 4'b1010};
    vt[2] = '{1'b0, 32'd3,        32'd3,        3'b001, 32'd0,        4'b0101};
    vt[3] = '{1'b1, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        4'b0101};
    vt[4] = '{1'b1, 32'd0,        32'd1,        3'b001, 32'hFFFFFFFF, 4'b0010};
    vt[5] = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 4'b0000};
    vt[6] = '{1'b1, 32'h80000000, 32'h80000000, 3'b000, 32'd0,        4'b1101};

    req0_a = 0; req0_b = 0; req0_f = 0; req1_a = 0; req1_b = 0; req1_f = 0;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    step(); step();
    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_result", rsp0_result, 32'd0);
    chk("rst_flags", 32'(rsp0_flags), 32'd0);
    reset = 1'b0;

    // table vectors; first one accepts on the first edge after reset release
    foreach (vt[i]) run_op(vt[i].r, vt[i].a, vt[i].b, vt[i].f, vt[i].er, vt[i].ef);

    // round-robin ties after reset: 0,1,0,1
    do_reset();
    req0_valid = 1; req1_valid = 1;
    req0_a = 32'd10; req0_b = 32'd1; req0_f = 3'b000;
    req1_a = 32'd20; req1_b = 32'd2; req1_f = 3'b000;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("tie_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
      chk("tie_req1_ready", 32'(req1_ready), 32'(k % 2 == 1));
      step();
      step();
      chk("tie_owner_valid", 32'(k % 2 ? rsp1_valid : rsp0_valid), 32'd1);
      chk("tie_result", rsp0_result, (k % 2) ? 32'd22 : 32'd11);
      if (k % 2) rsp1_ready = 1; else rsp0_ready = 1;
      step();
      rsp0_ready = 0; rsp1_ready = 0;
    end

    // response stall with req1 pending (last grant was 1, so req0 wins the tie)
    req0_a = 32'd9; req0_b = 32'd4; req0_f = 3'b001;
    #1;
    chk("stall_req0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 0;
    step();
    rsp1_ready = 1;  // non-owner ready must be ignored
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("stall_result", rsp0_result, 32'd5);
      chk("stall_req1_ready", 32'(req1_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      step();
    end
    rsp1_ready = 0; rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    chk("post_stall_req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 0;
    #1;
    chk("post_stall_accept", alu_a, 32'd20);
    chk("post_stall_busy", 32'(busy), 32'd1);
    step();
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // reset in EXEC drops the op
    req0_valid = 1; req0_a = 32'd55; req0_b = 32'd1; req0_f = 3'b000;
    #1;
    step();
    req0_valid = 0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_alu_a", alu_a, 32'd0);
    chk("async_rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_rsp_after_rst", 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);
    end

    // fixed priority: req1 never granted while req0 keeps asking
    do_reset();
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    acc = 0;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("fp_req1_ready", 32'(f_req1_ready), 32'd0);
      chk("fp_rsp1_valid", 32'(f_rsp1_valid), 32'd0);
      if (f_req0_ready) acc++;
      step();
    end
    chk("fp_req0_accepts", 32'(acc), 32'd4);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 always wins).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  requester has an operation pending.
- req0_ready / req1_ready  output  1  arbiter accepts the request this cycle.
- req0_a, req0_b / req1_a, req1_b  input  32  operands.
- req0_f / req1_f  input  3  ALU function code, passed through undecoded.
- rsp0_valid / rsp1_valid  output  1  result available for that requester.
- rsp0_ready / rsp1_ready  input  1  requester consumes the result.
- rsp0_result / rsp1_result  output  32  ALU result.
- rsp0_flags / rsp1_flags  output  4  {overflow, carry, negative, zero}.
- alu_a, alu_b  output  32  operands to the shared ALU.
- alu_f  output  3  function code to the shared ALU.
- alu_result  input  32  ALU result (combinational from alu_a/alu_b/alu_f).
- alu_zero, alu_overflow, alu_carry, alu_negative  input  1  ALU flags.
- busy  output  1  high whenever state is not IDLE.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-004 In IDLE, grant SHALL be combinational from req valids: one valid -> that requester; both valid -> RR_EN=1: requester not in last_grant; RR_EN=0: requester 0.
REQ-005 reqX_ready SHALL be 1 only when state==IDLE and requester X is granted; never both high; never high in EXEC or RESP.
REQ-006 Accept (reqX_valid && reqX_ready) SHALL register a, b, f into operand registers, record owner=X, update last_grant=X, move IDLE->EXEC.
REQ-007 alu_a, alu_b, alu_f SHALL be driven only from the operand registers (stable through EXEC and RESP).
REQ-008 In EXEC, alu_result and flags SHALL be captured into the result/flag registers; EXEC->RESP unconditionally (one cycle).
REQ-009 In RESP, rspX_valid SHALL be 1 for owner X only; result and flags SHALL hold stable until rspX_ready.
REQ-010 RESP with rspX_ready=1 SHALL return to IDLE next cycle; no new accept in the same cycle as response handshake.
REQ-011 Latency: accept at edge N -> rspX_valid high from cycle N+2; minimum throughput one op per 3 cycles.
REQ-012 rspY_ready for the non-owner SHALL be ignored; reqX_valid deassertion outside IDLE SHALL have no effect.
REQ-013 rsp1_result/flags and rsp0_result/flags SHALL both expose the shared result register; only valid gates ownership.
REQ-014 No arithmetic in this block; flags packed exactly as REQ-002 order from ALU inputs.

Reset
REQ-015 Reset SHALL asynchronously force: state=IDLE, operand/result/flag registers=0, owner=0, last_grant=1 (requester 0 wins first tie), all outputs 0 (alu_a/alu_b/alu_f=0, rsp valids=0, busy=0).
REQ-016 Reset asserted in EXEC or RESP SHALL drop the in-flight op; no rsp_valid after release until a new accept.
REQ-017 First accept SHALL be possible on the first rising edge with reset low.

Verification
REQ-018 req0: a=5, b=7, f=000 accepted at cycle N -> rsp0_valid at N+2, rsp0_result=12, rsp0_flags=4'b0000.
REQ-019 req0 and req1 valid in same cycle after reset (RR_EN=1) -> req0 served first, req1 accepted on first IDLE after rsp0 handshake; repeat tie -> req1 then req0 alternate.
REQ-020 req0: a=0x7FFFFFFF, b=1, f=000 -> result 0x80000000, flags=4'b1010; a=3, b=3, f=001 -> result 0, flags=4'b0101.
REQ-021 rsp0_ready held 0 for 4 cycles with req1_valid=1 -> rsp0_valid, rsp0_result stable, req1_ready=0, busy=1 throughout; rsp0_ready=1 -> IDLE, req1 accepted next cycle.
REQ-022 Reset pulsed while in EXEC -> all outputs 0 asynchronously, no rsp_valid afterward; RR_EN=0 with both valid repeatedly -> req1 never granted.
